// File: rtl/syscall_io_unit.sv
// syscall_io_unit
//   Services the two I/O syscalls of the processor.
//   Input syscall (op 110011): the processor is stalled while the user sets the
//   switches and presses then releases the confirm button. The switch value is
//   returned on in_data with a one-cycle in_valid strobe.
//   Output syscall (op 110111): rs_data is latched into a display register with
//   no stall. A continuously scanned 8-digit hex display shows this register.
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-high reset
//   op        in   opcode of the instruction in decode
//   rs_data   in   value to display on the output syscall
//   sw_in     in   user switches (asynchronous, sampled at capture)
//   btn_in    in   confirm button (asynchronous, bouncing, active-high)
//   cpu_stall out  high = processor holds PC and pipeline
//   in_data   out  captured switch value, zero-extended
//   in_valid  out  one-cycle strobe marking in_data valid for write-back
//   an        out  digit enables, active-low, one-hot-low
//   seg       out  segments a..g (seg[0]=a), active-low
module syscall_io_unit #(
    parameter int SW_WIDTH        = 16,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SCAN_DIV        = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5:0]          op,
    input  logic [31:0]         rs_data,
    input  logic [SW_WIDTH-1:0] sw_in,
    input  logic                btn_in,
    output logic                cpu_stall,
    output logic [31:0]         in_data,
    output logic                in_valid,
    output logic [7:0]          an,
    output logic [6:0]          seg
);

    localparam logic [5:0] OP_IN  = 6'b110011;
    localparam logic [5:0] OP_OUT = 6'b110111;

    localparam logic [1:0] IDLE         = 2'd0;
    localparam logic [1:0] WAIT_PRESS   = 2'd1;
    localparam logic [1:0] WAIT_RELEASE = 2'd2;
    localparam logic [1:0] DONE         = 2'd3;

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int SC_W = $clog2(SCAN_DIV + 1);

    // ---------------- button synchronizer and debouncer ----------------
    logic            btn_sync1, btn_sync2;
    logic            btn_level;
    logic [DB_W-1:0] db_cnt;

    // The level only flips after DEBOUNCE_CYCLES consecutive samples that
    // disagree with it; any agreeing sample restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_sync1 <= 1'b0;
            btn_sync2 <= 1'b0;
            btn_level <= 1'b0;
            db_cnt    <= '0;
        end else begin
            btn_sync1 <= btn_in;
            btn_sync2 <= btn_sync1;
            if (btn_sync2 != btn_level) begin
                if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    btn_level <= btn_sync2;
                    db_cnt    <= '0;
                end else begin
                    db_cnt <= db_cnt + DB_W'(1);
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    // ---------------- input syscall FSM ----------------
    logic [1:0] state, state_next;
    logic       capture;

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        case (state)
            IDLE:         if (op == OP_IN) state_next = WAIT_PRESS;
            WAIT_PRESS:   if (btn_level) begin
                              capture    = 1'b1;
                              state_next = WAIT_RELEASE;
                          end
            // WAIT_RELEASE only exits on a released button, so a new syscall
            // always starts from a low debounced level and needs a fresh press.
            WAIT_RELEASE: if (!btn_level) state_next = DONE;
            default:      state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            in_data <= 32'd0;
        end else begin
            state <= state_next;
            if (capture) in_data <= 32'(sw_in);
        end
    end

    assign in_valid  = (state == DONE);
    // Gated by rst so the stall reads its reset value while reset is held.
    assign cpu_stall = !rst && (((state == IDLE) && (op == OP_IN)) ||
                                (state == WAIT_PRESS) || (state == WAIT_RELEASE));

    // ---------------- output syscall and display scan ----------------
    logic [31:0]     disp;
    logic [SC_W-1:0] scan_cnt;
    logic [2:0]      digit_idx;
    logic [3:0]      nibble;
    logic [6:0]      glyph;

    assign nibble = disp[{digit_idx, 2'b00} +: 4];

    always_comb begin
        glyph = 7'b1111111;
        case (nibble)
            4'h0: glyph = 7'b1000000;
            4'h1: glyph = 7'b1111001;
            4'h2: glyph = 7'b0100100;
            4'h3: glyph = 7'b0110000;
            4'h4: glyph = 7'b0011001;
            4'h5: glyph = 7'b0010010;
            4'h6: glyph = 7'b0000010;
            4'h7: glyph = 7'b1111000;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0010000;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b0000011;
            4'hC: glyph = 7'b1000110;
            4'hD: glyph = 7'b0100001;
            4'hE: glyph = 7'b0000110;
            default: glyph = 7'b0001110;
        endcase
    end

    // an and seg are both registered from the same digit index so they
    // always switch on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp      <= 32'd0;
            scan_cnt  <= '0;
            digit_idx <= 3'd0;
            an        <= 8'hFE;
            seg       <= 7'b1000000;
        end else begin
            if ((state == IDLE) && (op == OP_OUT)) disp <= rs_data;
            if (scan_cnt == SC_W'(SCAN_DIV - 1)) begin
                scan_cnt  <= '0;
                digit_idx <= digit_idx + 3'd1;
            end else begin
                scan_cnt <= scan_cnt + SC_W'(1);
            end
            an  <= ~(8'b1 << digit_idx);
            seg <= glyph;
        end
    end

endmodule

// File: tb/tb_syscall_io_unit.sv
module tb_syscall_io_unit;

    localparam int SW = 16;
    localparam int DB = 4;
    localparam int SD = 4;
    localparam logic [5:0] OP_IN  = 6'b110011;
    localparam logic [5:0] OP_OUT = 6'b110111;

    logic          clk = 1'b0;
    logic          rst;
    logic [5:0]    op;
    logic [31:0]   rs_data;
    logic [SW-1:0] sw_in;
    logic          btn_in;
    logic          cpu_stall;
    logic [31:0]   in_data;
    logic          in_valid;
    logic [7:0]    an;
    logic [6:0]    seg;

    syscall_io_unit #(
        .SW_WIDTH        (SW),
        .DEBOUNCE_CYCLES (DB),
        .SCAN_DIV        (SD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .op        (op),
        .rs_data   (rs_data),
        .sw_in     (sw_in),
        .btn_in    (btn_in),
        .cpu_stall (cpu_stall),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .an        (an),
        .seg       (seg)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int vcount = 0;
    logic [31:0] exp_in_data;
    logic [31:0] exp_disp;
    logic [6:0]  glyph_tab [16];

    // Strobe counter: in_valid is sampled mid-cycle.
    always @(negedge clk) if (in_valid === 1'b1) vcount++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs();
        check("rst_stall", cpu_stall, 0);
        check("rst_valid", in_valid, 0);
        check("rst_in_data", in_data, 0);
        check("rst_an", an, 8'hFE);
        check("rst_seg", seg, 7'b1000000);
    endtask

    // Watch one full scan period: every cycle one digit enabled showing the
    // glyph of its nibble, digits advance by one, each for SD cycles.
    task automatic check_display();
        int cnt [8];
        int idx;
        int prev;
        prev = -1;
        for (int i = 0; i < 8; i++) cnt[i] = 0;
        for (int c = 0; c < 8 * SD; c++) begin
            tick();
            idx = -1;
            for (int i = 0; i < 8; i++) if (an == ~(8'b1 << i)) idx = i;
            check("an_onehot", (idx >= 0), 1);
            if (idx >= 0) begin
                check("seg_glyph", seg, glyph_tab[exp_disp[4*idx +: 4]]);
                cnt[idx]++;
                if (prev >= 0 && idx != prev) check("digit_step", idx, (prev + 1) % 8);
                prev = idx;
            end
        end
        for (int i = 0; i < 8; i++) check("digit_dwell", cnt[i], SD);
    endtask

    // Full input syscall: bounce first (must be ignored), then a clean press
    // held 10 cycles and a release.
    task automatic do_input(input logic [SW-1:0] sw, input bit keep_op);
        int v0;
        bit got;
        op     = OP_IN;
        sw_in  = sw;
        btn_in = 1'b0;
        #1;
        check("stall_first", cpu_stall, 1);
        v0 = vcount;
        for (int k = 0; k < 3; k++) begin
            tick();
            btn_in = 1'b1;
            tick();
            btn_in = 1'b0;
            tick();
            tick();
        end
        tick();
        tick();
        check("bounce_stall", cpu_stall, 1);
        check("bounce_valid", vcount, v0);
        check("bounce_data", in_data, exp_in_data);
        btn_in = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("press_stall", cpu_stall, 1);
        end
        exp_in_data = 32'(sw);
        check("capture", in_data, exp_in_data);
        btn_in = 1'b0;
        got = 1'b0;
        for (int w = 0; w < 40 && !got; w++) begin
            tick();
            if (in_valid === 1'b1) got = 1'b1;
            else check("release_stall", cpu_stall, 1);
        end
        check("valid_seen", got, 1);
        if (got) begin
            check("done_stall", cpu_stall, 0);
            check("done_data", in_data, exp_in_data);
        end
        if (!keep_op) op = 6'd0;
        tick();
        check("valid_single", in_valid, 0);
        check("valid_count", vcount, v0 + 1);
        check("data_hold", in_data, exp_in_data);
    endtask

    task automatic do_output(input logic [31:0] val);
        op      = OP_OUT;
        rs_data = val;
        #1;
        check("out_stall", cpu_stall, 0);
        tick();
        exp_disp = val;
        op = 6'd0;
        check("out_valid", in_valid, 0);
        check("out_stall_after", cpu_stall, 0);
        tick();
        tick();
        check_display();
    endtask

    initial begin
        glyph_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        rst = 1'b1; op = 6'd0; rs_data = 32'd0; sw_in = '0; btn_in = 1'b0;
        exp_in_data = 32'd0;
        exp_disp    = 32'd0;

        tick(); tick(); tick();
        check_reset_outputs();
        rst = 1'b0;
        tick();
        check("idle_stall", cpu_stall, 0);

        // Basic input syscall, then a random one.
        do_input(16'hBEEF, 1'b0);
        check("beef_data", in_data, 32'h0000BEEF);
        do_input(SW'($urandom), 1'b0);

        // Output syscalls.
        do_output(32'h12345678);
        do_output($urandom);
        do_output($urandom);

        // Ignored opcodes must not stall, strobe or touch the display.
        op = 6'b000000; rs_data = $urandom;
        #1; check("nop_stall", cpu_stall, 0);
        tick(); check("nop_valid", in_valid, 0);
        op = 6'b100011; rs_data = $urandom;
        #1; check("lw_stall", cpu_stall, 0);
        tick(); check("lw_valid", in_valid, 0);
        op = 6'd0;
        check_display();

        // Scanning continues while the processor is stalled.
        op = OP_IN;
        #1;
        check_display();
        check("scan_stall", cpu_stall, 1);
        do_input(SW'($urandom), 1'b0);

        // Back-to-back input syscalls: the second needs its own press.
        do_input(SW'($urandom), 1'b1);
        for (int k = 0; k < 12; k++) begin
            tick();
            check("b2b_wait_stall", cpu_stall, 1);
            check("b2b_wait_valid", in_valid, 0);
        end
        do_input(SW'($urandom), 1'b0);

        // Reset while waiting for release abandons the syscall.
        begin
            int v0;
            logic [SW-1:0] sw;
            sw = SW'($urandom);
            v0 = vcount;
            op = OP_IN; sw_in = sw; btn_in = 1'b1;
            for (int k = 0; k < 10; k++) tick();
            check("mid_capture", in_data, 32'(sw));
            rst = 1'b1;
            #1;
            check_reset_outputs();
            btn_in = 1'b0;
            tick(); tick(); tick();
            check_reset_outputs();
            rst = 1'b0;
            exp_in_data = 32'd0;
            exp_disp    = 32'd0;
            #1;
            check("rst_restall", cpu_stall, 1);
            check("rst_no_valid", vcount, v0);
            check_display();
            do_input(SW'($urandom), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/syscall_io_unit.md
SYSCALL_IO_UNIT -- requirements
Module: syscall_io_unit

Interface
REQ-001 The block SHALL have exactly one clock and one asynchronous, active-high reset.
REQ-002 Parameter SW_WIDTH, default 16: width of the user switch bank.
REQ-003 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable synchronized samples needed to accept a button level change.
REQ-004 Parameter SCAN_DIV, default 4: clock cycles each display digit stays enabled.
REQ-005 clk  in  1  system clock; all state changes on its rising edge.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 op  in  6  opcode of the instruction currently in decode.
REQ-008 rs_data  in  32  register value to display on the output syscall.
REQ-009 sw_in  in  SW_WIDTH  user switches, asynchronous to clk.
REQ-010 btn_in  in  1  user confirm button, asynchronous, active-high, bouncing.
REQ-011 cpu_stall  out  1  high = processor holds PC and pipeline.
REQ-012 in_data  out  32  captured switch value, zero-extended.
REQ-013 in_valid  out  1  one-cycle strobe; in_data is valid for register write-back.
REQ-014 an  out  8  digit enables, active-low, one-hot-low.
REQ-015 seg  out  7  segments a..g (seg[0]=a), active-low.

Function
REQ-016 The input syscall opcode SHALL be 6'b110011 and the output syscall opcode 6'b110111; all other opcodes are ignored.
REQ-017 btn_in SHALL pass through a 2-flop synchronizer, then a debouncer that updates its level only after DEBOUNCE_CYCLES consecutive equal samples differ from the current level.
REQ-018 Input FSM states SHALL be IDLE, WAIT_PRESS, WAIT_RELEASE, DONE.
REQ-019 IDLE: op==input opcode -> WAIT_PRESS next cycle; otherwise stay.
REQ-020 WAIT_PRESS: debounced button high -> capture sw_in into in_data (upper bits zero) and go to WAIT_RELEASE.
REQ-021 WAIT_RELEASE: debounced button low -> DONE.
REQ-022 DONE: in_valid=1 for exactly this cycle, then IDLE unconditionally.
REQ-023 cpu_stall SHALL be combinational: high when (IDLE and op==input opcode), WAIT_PRESS or WAIT_RELEASE; low in DONE, so the syscall retires at the DONE edge.
REQ-024 Back-to-back input syscalls SHALL each need a full press-and-release; a button held across DONE is not accepted until released and pressed again.
REQ-025 in_data SHALL hold its value until the next capture.
REQ-026 Output syscall: in IDLE with op==output opcode, rs_data SHALL be latched into a 32-bit display register at that edge, with no stall; op is ignored outside IDLE.
REQ-027 The scan counter SHALL count 0..SCAN_DIV-1. On wrap, the digit index (0..7) SHALL advance, wrapping 7->0.
REQ-028 an SHALL drive low only bit [digit index]; seg SHALL show the hex glyph 0-F of nibble [4*idx+3:4*idx] of the display register. an and seg SHALL be registered so they change together.
REQ-029 Display scanning SHALL run continuously, including while cpu_stall is high.

Reset
REQ-030 While rst is high: state=IDLE, in_data=0, in_valid=0, display register=0, scan counter=0, digit index=0, an=8'hFE, seg = glyph '0' (7'b1000000), synchronizer and debounce level=0, debounce counter=0.
REQ-031 If rst is asserted mid-operation, the pending input SHALL be abandoned with no in_valid. After release, an input opcode still present on op restarts the sequence from IDLE.

Verification
REQ-032 op=110011, sw_in=16'hBEEF, clean press held 10 cycles then released -> cpu_stall high from the first cycle until DONE; in_valid single pulse; in_data=32'h0000BEEF.
REQ-033 Button bounce: 1-cycle pulses shorter than DEBOUNCE_CYCLES during WAIT_PRESS -> no capture; state stays WAIT_PRESS.
REQ-034 op=110111, rs_data=32'h12345678 -> no stall; over 8*SCAN_DIV cycles an walks FE,FD,...,7F with seg glyphs 8,7,6,5,4,3,2,1.
REQ-035 Two consecutive input syscalls with the button held through the first DONE -> second in_valid only after release and a new press.
REQ-036 rst asserted in WAIT_RELEASE -> all outputs at reset values, no in_valid; op still 110011 after release -> cpu_stall high again.
REQ-037 Opcodes 000000 and 100011 in IDLE -> cpu_stall=0, in_valid=0, display register unchanged.
